// File: rtl/bmp_pixel_packer.sv
// BMP byte stream to 24-bit pixel packer: strips the file header and the row padding,
// then packs three bytes per pixel into the downstream pixel FIFO.
module bmp_pixel_packer #(
  parameter int HEADER_BYTES = 54,
  parameter int WIDTH        = 720,
  parameter int HEIGHT       = 540
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_dout,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [23:0] out_din,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic        frame_done
);
  localparam int ROW_PAD = (4 - (WIDTH * 3) % 4) % 4;
  localparam int HW = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (ROW_PAD > 1) ? $clog2(ROW_PAD) : 1;
  localparam logic [HW-1:0] HDR_LAST = HW'(HEADER_BYTES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [PW-1:0] PAD_LAST = PW'((ROW_PAD > 0) ? ROW_PAD - 1 : 0);

  typedef enum logic [1:0] {S_HDR, S_PIX, S_PAD} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hdr_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] pad_cnt;
  logic [1:0]    byte_idx;
  logic [15:0]   asm_reg;
  logic          pix_valid, last_pend, pop_ok;
  logic          pix_done, row_end, last_row, hdr_end, pad_end;

  assign last_row = (row == ROW_LAST);
  assign hdr_end  = in_rd_en && state == S_HDR && hdr_cnt == HDR_LAST;
  assign pix_done = in_rd_en && state == S_PIX && byte_idx == 2'd2;
  assign row_end  = pix_done && col == COL_LAST;
  assign pad_end  = in_rd_en && state == S_PAD && pad_cnt == PAD_LAST;

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_HDR;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR: if (hdr_end) state_nx = S_PIX;
      S_PIX: if (row_end) begin
        if (ROW_PAD > 0)   state_nx = S_PAD;
        else if (last_row) state_nx = S_HDR;
      end
      S_PAD: if (pad_end) state_nx = last_row ? S_HDR : S_PIX;
      default: state_nx = S_HDR;
    endcase
  end

  // Bytes 0 and 1 go to asm_reg, so only the completing byte has to wait for the held pixel.
  always_comb begin
    out_wr_en = pix_valid && !out_full;
    pop_ok    = 1'b0;
    case (state)
      S_HDR, S_PAD: pop_ok = 1'b1;
      S_PIX:        pop_ok = (byte_idx != 2'd2) || !pix_valid || out_wr_en;
      default:      pop_ok = 1'b0;
    endcase
    in_rd_en = reset && !in_empty && pop_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hdr_cnt  <= '0;
      col      <= '0;
      row      <= '0;
      pad_cnt  <= '0;
      byte_idx <= '0;
      asm_reg  <= '0;
      out_din  <= '0;
    end else if (in_rd_en) begin
      case (state)
        S_HDR: hdr_cnt <= hdr_end ? '0 : hdr_cnt + HW'(1);
        S_PIX: begin
          case (byte_idx)
            2'd0:    begin asm_reg[7:0]  <= in_dout; byte_idx <= 2'd1; end
            2'd1:    begin asm_reg[15:8] <= in_dout; byte_idx <= 2'd2; end
            default: begin
              out_din  <= {in_dout, asm_reg};
              byte_idx <= 2'd0;
              if (col == COL_LAST) begin
                col <= '0;
                if (ROW_PAD == 0) row <= last_row ? '0 : row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          endcase
        end
        // With padding the row index advances once the pad is consumed, keeping it in range.
        S_PAD: begin
          if (pad_end) begin
            pad_cnt <= '0;
            row     <= last_row ? '0 : row + RW'(1);
          end else begin
            pad_cnt <= pad_cnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_valid  <= 1'b0;
      last_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (pix_done)       pix_valid <= 1'b1;
      else if (out_wr_en) pix_valid <= 1'b0;
      if (row_end && last_row) last_pend <= 1'b1;
      else if (out_wr_en)      last_pend <= 1'b0;
      frame_done <= out_wr_en && last_pend;
    end
  end
endmodule

// File: tb/tb_bmp_pixel_packer.sv
// Drives a padded (3x2) and an unpadded (4x3) packer from byte queues and scores their
// pixel writes against per-frame golden pixel lists built from the generated files.
module tb_bmp_pixel_packer;
  localparam int HB = 54;
  localparam int WA = 3, HA = 2, WB = 4, HBT = 3;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [7:0]  dout [2];
  logic        empty [2], rd [2], full [2], wr [2], fd [2];
  logic [23:0] din [2];

  logic [7:0]  byte_q [2][$];
  logic [23:0] gold_q [2][$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, empty_pct = 0, full_pct = 0;
  bit hold_full = 0;
  int pops [2], wrs [2], fds [2], miss [2], last_wr [2], first_wr [2];

  always #5 clk = ~clk;

  bmp_pixel_packer #(.HEADER_BYTES(HB), .WIDTH(WA), .HEIGHT(HA)) u_a (
    .clock(clk), .reset(rst_n), .in_dout(dout[0]), .in_empty(empty[0]), .in_rd_en(rd[0]),
    .out_din(din[0]), .out_full(full[0]), .out_wr_en(wr[0]), .frame_done(fd[0]));
  bmp_pixel_packer #(.HEADER_BYTES(HB), .WIDTH(WB), .HEIGHT(HBT)) u_b (
    .clock(clk), .reset(rst_n), .in_dout(dout[1]), .in_empty(empty[1]), .in_rd_en(rd[1]),
    .out_din(din[1]), .out_full(full[1]), .out_wr_en(wr[1]), .frame_done(fd[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int wid(input int k); return k ? WB : WA; endfunction
  function automatic int hgt(input int k); return k ? HBT : HA; endfunction

  task automatic gen_frame(input int k);
    int pad;
    logic [7:0] b0, b1, b2;
    pad = (4 - (wid(k) * 3) % 4) % 4;
    for (int i = 0; i < HB; i++) byte_q[k].push_back(8'hFF);
    for (int r = 0; r < hgt(k); r++) begin
      for (int c = 0; c < wid(k); c++) begin
        b0 = 8'($urandom_range(0, 8'hED));
        b1 = 8'($urandom_range(0, 8'hED));
        b2 = 8'($urandom_range(0, 8'hED));
        byte_q[k].push_back(b0); byte_q[k].push_back(b1); byte_q[k].push_back(b2);
        gold_q[k].push_back({b2, b1, b0});
      end
      for (int p = 0; p < pad; p++) byte_q[k].push_back(8'hEE);
    end
  endtask

  // Called at a falling edge: present inputs, sample outputs, then wait for the next falling edge.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      empty[k] = (byte_q[k].size() == 0) || ($urandom_range(0, 99) < empty_pct);
      dout[k]  = (byte_q[k].size() != 0) ? byte_q[k][0] : 8'h00;
      full[k]  = hold_full || ($urandom_range(0, 99) < full_pct);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (fd[k]) begin
        fds[k]++;
        chk($sformatf("fd_after_last%0d", k),
            32'(last_wr[k] == cyc - 1 && wrs[k] % (wid(k) * hgt(k)) == 0), 32'd1);
      end
      if (rd[k]) begin
        if (empty[k]) chk($sformatf("rd_when_empty%0d", k), 32'd1, 32'd0);
        else void'(byte_q[k].pop_front());
        pops[k]++;
      end else if (rst_n && !empty[k] && full_pct == 0 && !hold_full) begin
        miss[k]++;
      end
      if (wr[k]) begin
        if (gold_q[k].size() == 0) chk($sformatf("extra_wr%0d", k), 32'(din[k]), 32'hFFFFFFFF);
        else chk($sformatf("pix%0d_%0d", k, wrs[k]), 32'(din[k]), 32'(gold_q[k].pop_front()));
        if (wrs[k] == 0) first_wr[k] = cyc;
        wrs[k]++;
        last_wr[k] = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((byte_q[0].size() + byte_q[1].size() + gold_q[0].size() + gold_q[1].size()) != 0
           && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      pops[k] = 0; wrs[k] = 0; fds[k] = 0; miss[k] = 0; last_wr[k] = -10; first_wr[k] = -1;
    end
    cyc = 0;
  endtask

  initial begin
    int hold_pops, late_pops, hold_wr, n;
    clear_stats();
    for (int k = 0; k < 2; k++) begin empty[k] = 1'b0; dout[k] = 8'h55; full[k] = 1'b0; end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rd%0d", k), 32'(rd[k]), 32'd0);
      chk($sformatf("rst_wr%0d", k), 32'(wr[k]), 32'd0);
      chk($sformatf("rst_din%0d", k), 32'(din[k]), 32'd0);
      chk($sformatf("rst_fd%0d", k), 32'(fd[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // One clean frame each, no bubbles, no backpressure.
    gen_frame(0); gen_frame(1);
    drain(2000);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("first_wr_cyc%0d", k), 32'(first_wr[k]), 32'(HB + 3));
      chk($sformatf("wr_cnt%0d", k), 32'(wrs[k]), 32'(wid(k) * hgt(k)));
      chk($sformatf("fd_cnt%0d", k), 32'(fds[k]), 32'd1);
      chk($sformatf("rd_every_cyc%0d", k), 32'(miss[k]), 32'd0);
    end

    // Two back-to-back frames with random bubbles and backpressure.
    clear_stats();
    empty_pct = 50; full_pct = 30;
    for (int f = 0; f < 2; f++) begin gen_frame(0); gen_frame(1); end
    drain(5000);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rnd_wr_cnt%0d", k), 32'(wrs[k]), 32'(2 * wid(k) * hgt(k)));
      chk($sformatf("rnd_fd_cnt%0d", k), 32'(fds[k]), 32'd2);
    end

    // Hold the pixel FIFO full for 20 cycles in the middle of a row of the unpadded instance.
    clear_stats();
    empty_pct = 0; full_pct = 0;
    gen_frame(0); gen_frame(1);
    n = 0;
    while (pops[1] < HB + 3 * WB + 4 && n < 500) begin step(); n++; end
    chk("hold_reach", 32'(n < 500), 32'd1);
    hold_full = 1; hold_pops = 0; late_pops = 0; hold_wr = 0;
    for (int i = 0; i < 20; i++) begin
      n = pops[1];
      step();
      hold_pops += pops[1] - n;
      if (i >= 10) late_pops += pops[1] - n;
      hold_wr += (last_wr[0] == cyc - 1 || last_wr[1] == cyc - 1) ? 1 : 0;
    end
    chk("hold_no_wr", 32'(hold_wr), 32'd0);
    chk("hold_pops_le5", 32'(hold_pops <= 5), 32'd1);
    chk("hold_stalled", 32'(late_pops), 32'd0);
    hold_full = 0;
    drain(2000);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold_wr_cnt%0d", k), 32'(wrs[k]), 32'(wid(k) * hgt(k)));
      chk($sformatf("hold_fd_cnt%0d", k), 32'(fds[k]), 32'd1);
    end

    // Reset while the unpadded instance has popped byte 0 of its third pixel.
    clear_stats();
    gen_frame(0); gen_frame(1);
    n = 0;
    while (pops[1] < HB + 7 && n < 500) begin step(); n++; end
    chk("mid_reach", 32'(n < 500), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mid_rst_rd%0d", k), 32'(rd[k]), 32'd0);
      chk($sformatf("mid_rst_wr%0d", k), 32'(wr[k]), 32'd0);
      chk($sformatf("mid_rst_din%0d", k), 32'(din[k]), 32'd0);
      chk($sformatf("mid_rst_fd%0d", k), 32'(fd[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin byte_q[k].delete(); gold_q[k].delete(); end
    clear_stats();
    empty_pct = 30; full_pct = 20;
    gen_frame(0); gen_frame(1);
    drain(3000);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_rst_wr_cnt%0d", k), 32'(wrs[k]), 32'(wid(k) * hgt(k)));
      chk($sformatf("post_rst_fd_cnt%0d", k), 32'(fds[k]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
